photon_window_counter: RTL and testbench

Synchronous front end for the laser high/low decision stage. It synchronises the asynchronous photon input, counts photon rising edges inside a sequencer-driven readout window, and delivers one registered count per window with a valid/ready handshake. It also provides a precomputed above-threshold bit. The downstream comparator consumes one result per readout, so it no longer has to clock logic from the photon line.

---
 rtl/photon_window_counter.sv | 160 ++++++++++++++++
 tb/tb_photon_window_counter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/photon_window_counter.sv
// Photon window counter: synchronises the photon line, counts rising edges while the
// readout gate is high, and presents one registered result per window over valid/ready.
module photon_window_counter #(
    parameter int unsigned COUNT_WIDTH = 25,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned THRESHOLD   = 4095
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   photon,
    input  logic                   gate,
    input  logic                   out_ready,
    input  logic                   err_clear,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_above,
    output logic                   out_sat,
    output logic                   out_valid,
    output logic                   overrun,
    output logic                   busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_THR  = COUNT_WIDTH'(THRESHOLD);

    // Photon synchroniser and edge detector
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   photon_s;
    logic                   photon_edge;

    assign photon_s    = sync_q[SYNC_STAGES-1];
    assign photon_edge = photon_s & ~edge_q;

    // NOTE: sequential state always uses non-blocking (<=) so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], photon};
            edge_q <= photon_s;
        end
    end

    // Window FSM with its counter and saturation flag
    state_e                 state_q;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic                   sat_q;
    logic                   busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gate) begin
                        state_q <= COUNT;
                        busy_q  <= 1'b1;
                        cnt_q   <= photon_edge ? CNT_ONE : '0;
                        sat_q   <= 1'b0;
                    end
                end
                COUNT: begin
                    if (!gate) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (photon_edge) begin
                        // sat marks that at least one edge was lost at all-ones
                        if (cnt_q == CNT_MAX) begin
                            sat_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output register and overrun flag
    logic                   window_done;
    logic                   accept;
    logic                   load;
    logic                   drop;

    logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                   out_above_q, out_above_d;
    logic                   out_sat_q,   out_sat_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overrun_q,   overrun_d;

    assign window_done = (state_q == COUNT) && !gate;
    assign accept      = out_valid_q && out_ready;
    assign load        = window_done && (!out_valid_q || out_ready);
    assign drop        = window_done && out_valid_q && !out_ready;

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        out_count_d = out_count_q;
        out_above_d = out_above_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        if (load) begin
            out_count_d = cnt_q;
            out_above_d = (cnt_q > CNT_THR);
            out_sat_d   = sat_q;
            out_valid_d = 1'b1;
        end else if (accept) begin
            out_valid_d = 1'b0;
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (err_clear) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_count_q <= '0;
            out_above_q <= 1'b0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_count_q <= out_count_d;
            out_above_q <= out_above_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_count = out_count_q;
    assign out_above = out_above_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_photon_window_counter.sv
// Bench for photon_window_counter: a wide default instance and a narrow saturating
// instance share stimulus; a window-level reference model predicts both every cycle.
module tb_photon_window_counter;

    logic clk = 1'b0;
    logic reset;
    logic photon;
    logic gate;
    logic out_ready;
    logic err_clear;

    logic [24:0] cnt_a;
    logic        above_a, sat_a, valid_a, ovr_a, busy_a;
    logic [3:0]  cnt_b;
    logic        above_b, sat_b, valid_b, ovr_b, busy_b;

    int n_vec = 0;
    int n_err = 0;
    int win_n = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    photon_window_counter dut_a (
        .clk(clk), .reset(reset), .photon(photon), .gate(gate),
        .out_ready(out_ready), .err_clear(err_clear),
        .out_count(cnt_a), .out_above(above_a), .out_sat(sat_a),
        .out_valid(valid_a), .overrun(ovr_a), .busy(busy_a)
    );

    photon_window_counter #(.COUNT_WIDTH(4), .SYNC_STAGES(2), .THRESHOLD(10)) dut_b (
        .clk(clk), .reset(reset), .photon(photon), .gate(gate),
        .out_ready(out_ready), .err_clear(err_clear),
        .out_count(cnt_b), .out_above(above_b), .out_sat(sat_b),
        .out_valid(valid_b), .overrun(ovr_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one result per window, count = photons placed in the window,
    // clipped to the counter range; handshake rules applied at window granularity.
    function automatic int max_of(int d);
        return (d == 0) ? 33554431 : 15;
    endfunction

    function automatic int thr_of(int d);
        return (d == 0) ? 4095 : 10;
    endfunction

    function automatic int clip(int n, int d);
        return (n > max_of(d)) ? max_of(d) : n;
    endfunction

    logic m_gate;
    int   m_count [2];
    logic m_above [2];
    logic m_sat   [2];
    logic m_valid [2];
    logic m_over  [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_gate <= 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_count[d] <= 0;
                m_above[d] <= 1'b0;
                m_sat[d]   <= 1'b0;
                m_valid[d] <= 1'b0;
                m_over[d]  <= 1'b0;
            end
        end else begin
            m_gate <= gate;
            for (int d = 0; d < 2; d++) begin
                if (m_gate && !gate && (!m_valid[d] || out_ready)) begin
                    m_valid[d] <= 1'b1;
                    m_count[d] <= clip(win_n, d);
                    m_above[d] <= clip(win_n, d) > thr_of(d);
                    m_sat[d]   <= win_n > max_of(d);
                end else if (out_ready) begin
                    m_valid[d] <= 1'b0;
                end
                if (m_gate && !gate && m_valid[d] && !out_ready) m_over[d] <= 1'b1;
                else if (err_clear) m_over[d] <= 1'b0;
            end
        end
    end

    task automatic check_dut(input string name, input logic [31:0] cnt, input logic above,
                             input logic sat, input logic valid, input logic ovr,
                             input logic bsy, input int e_cnt, input logic e_above,
                             input logic e_sat, input logic e_valid, input logic e_ovr,
                             input logic e_bsy);
        check({name, ".out_count"}, cnt, e_cnt);
        check({name, ".out_above"}, 32'(above), 32'(e_above));
        check({name, ".out_sat"},   32'(sat),   32'(e_sat));
        check({name, ".out_valid"}, 32'(valid), 32'(e_valid));
        check({name, ".overrun"},   32'(ovr),   32'(e_ovr));
        check({name, ".busy"},      32'(bsy),   32'(e_bsy));
    endtask

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check_dut("A", 32'(cnt_a), above_a, sat_a, valid_a, ovr_a, busy_a,
                      m_count[0], m_above[0], m_sat[0], m_valid[0], m_over[0], m_gate);
            check_dut("B", 32'(cnt_b), above_b, sat_b, valid_b, ovr_b, busy_b,
                      m_count[1], m_above[1], m_sat[1], m_valid[1], m_over[1], m_gate);
        end
    end

    task automatic check_all_zero(input string tag);
        check_dut({tag, ".A"}, 32'(cnt_a), above_a, sat_a, valid_a, ovr_a, busy_a,
                  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_dut({tag, ".B"}, 32'(cnt_b), above_b, sat_b, valid_b, ovr_b, busy_b,
                  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Photon edges land off the clock edge to exercise the synchroniser.
    task automatic pulse(input int hi, input int lo, input bit rand_rdy);
        #2 photon = 1'b1;
        repeat (hi) @(negedge clk);
        #2 photon = 1'b0;
        repeat (lo) @(negedge clk);
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic open_window();
        @(negedge clk);
        gate = 1'b1;
        @(negedge clk);
    endtask

    task automatic close_window(input int n, input bit pulses_sent, input bit set_rdy);
        if (pulses_sent) repeat (6) @(negedge clk);
        win_n = n;
        gate  = 1'b0;
        if (set_rdy) out_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic window(input int n, input int hi, input int lo, input bit rand_rdy);
        open_window();
        for (int i = 0; i < n; i++) pulse(hi, lo, rand_rdy);
        close_window(n, n > 0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; photon = 1'b0; gate = 1'b0; out_ready = 1'b0; err_clear = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset  = 1'b0;
        chk_en = 1'b1;

        // Basic window: 5 pulses, 3 wide, 6 apart
        out_ready = 1'b1;
        window(5, 3, 3, 1'b0);

        // Saturation of the narrow instance
        window(20, 2, 2, 1'b0);

        // Threshold boundary on the wide instance
        window(4095, 2, 2, 1'b0);
        window(4096, 2, 2, 1'b0);

        // Overrun: two windows held, then clear and drain
        out_ready = 1'b0;
        window(3, 2, 3, 1'b0);
        window(7, 2, 3, 1'b0);
        @(negedge clk); err_clear = 1'b1;
        @(negedge clk); err_clear = 1'b0;
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Back-to-back: second window ends as ready rises
        out_ready = 1'b0;
        window(6, 2, 2, 1'b0);
        open_window();
        for (int i = 0; i < 9; i++) pulse(2, 2, 1'b0);
        close_window(9, 1'b1, 1'b1);

        // Reset in the middle of a counting window
        open_window();
        for (int i = 0; i < 4; i++) pulse(2, 2, 1'b0);
        #2 reset = 1'b1;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        gate = 1'b0; photon = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        window(2, 2, 3, 1'b0);

        // One-cycle windows with no photons, with ready low and high
        window(0, 1, 1, 1'b0);
        out_ready = 1'b0;
        window(0, 1, 1, 1'b0);
        window(0, 1, 1, 1'b0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Randomised windows with random ready and err_clear
        for (int k = 0; k < 40; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                err_clear = 1'b1;
                @(negedge clk);
                err_clear = 1'b0;
            end
            window($urandom_range(0, 20), $urandom_range(2, 3), $urandom_range(2, 4), 1'b1);
        end

        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
